sdr_cpu_audio_arbiter: RTL
==========================

# sdr_cpu_audio_arbiter

Shares one SDRAM read channel between the CPU ROM cache and the sound block's sample/program fetcher. Requests are serviced one at a time, with CPU priority bounded by a starvation limit so audio fetches always progress. Each requester gets its own ready pulse and its own held read-data register. The block sits between the `rom_cache`/`sound` SDRAM ports and a single `sdr_*` port of the SDRAM controller.

## Interface
Parameters:
- `ADDR_W`, 25: SDRAM word address width.
- `DATA_W`, 64: read data width.
- `CPU_BURST`, 4: maximum consecutive CPU grants while audio is pending. 0 gives audio strict priority.

Ports:
- `clk_sys`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  ADDR_W  CPU request address; stable while `cpu_req` is high.
- `cpu_req`  in  1  CPU request level.
- `cpu_rdy`  out  1  one-cycle completion pulse to the CPU.
- `cpu_dout`  out  DATA_W  last CPU read data; held between completions.
- `aud_addr`  in  ADDR_W  audio request address.
- `aud_req`  in  1  audio request level.
- `aud_rdy`  out  1  one-cycle completion pulse to audio.
- `aud_dout`  out  DATA_W  last audio read data; held between completions.
- `sdr_addr`  out  ADDR_W  address to the SDRAM controller.
- `sdr_req`  out  1  request to the controller; level, held until `sdr_rdy`.
- `sdr_rdy`  in  1  controller completion pulse.
- `sdr_dout`  in  DATA_W  controller read data; valid with `sdr_rdy`.
- `busy`  out  1  high whenever the state is not IDLE.
- `owner`  out  2  current grant: 00 none, 01 CPU, 10 audio.

## Operation
- States:
  - IDLE: wait for a request, then pick a winner.
  - WAIT: transaction outstanding.
  - RELEASE: one cycle; all requests ignored.
- IDLE, neither request high: stay in IDLE.
- IDLE, any request high:
  - Choose the winner.
  - Latch the winner's address into `sdr_addr`.
  - Set `owner` and `sdr_req`=1, then go to WAIT.
- Winner selection:
  - Audio wins if `aud_req` & (~`cpu_req` | `streak`==`CPU_BURST`).
  - Otherwise the CPU wins.
- `streak` counter, width $clog2(CPU_BURST+1), saturating:
  - CPU grant with `aud_req` high: `streak` increments.
  - CPU grant with `aud_req` low: `streak` clears.
  - Audio grant: `streak` clears.
- WAIT:
  - `sdr_req` and `sdr_addr` are held.
  - On `sdr_rdy`, `sdr_dout` is written into the owner's dout register.
  - The owner's rdy is pulsed and `sdr_req` drops; the state goes to RELEASE.
- RELEASE:
  - `owner` returns to 00 and the state returns to IDLE.
  - This guarantees a requester has one cycle to drop `req` after its rdy pulse.
- Handshake rules for requesters:
  - Assert `req` with `addr` stable and hold it until the rdy pulse.
  - Deassert `req` no later than the cycle after rdy, or keep it high to issue a new request at the same or a new address.
  - A `req` still high in IDLE is treated as a new request.
- Boundary conditions:
  - `req` dropped during WAIT: the transaction completes and the rdy pulse is still issued. dout is updated; the requester ignores it.
  - `sdr_rdy` in IDLE or RELEASE: ignored; no state or data change.
  - Both requests rising in the same IDLE cycle: resolved by the winner rule above.
  - The non-winner's dout is never modified by another requester's transaction.
- Reset, including mid-WAIT:
  - Outputs go to: `sdr_req`=0, `sdr_addr`=0, `cpu_rdy`=`aud_rdy`=0, `cpu_dout`=`aud_dout`=0, `owner`=00, `busy`=0.
  - `streak` clears and the state returns to IDLE.
  - The SDRAM controller is reset by the same signal, so no stray `sdr_rdy` can arrive later.

## Timing
- Cycle 0: `req` sampled in IDLE.
- Cycle 1: `sdr_req`=1, `sdr_addr` valid, `owner` set.
- `sdr_rdy` seen at cycle k (k>=1):
  - Cycle k+1: rdy pulse high and dout valid; `sdr_req`=0; state RELEASE.
  - Cycle k+2: IDLE.
  - Cycle k+3: earliest next `sdr_req`.
- Minimum request-to-rdy latency is 2 cycles plus controller latency. Minimum spacing between `sdr_req` assertions is 2 idle cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset values: assert `reset` asynchronously mid-cycle -> all outputs 0 immediately; release with no requests -> `busy`=0 and `sdr_req` stays 0.
- Single CPU read:
  - Stimulus: `cpu_addr`=0x0012340, `cpu_req`=1; controller returns `sdr_rdy` 5 cycles after `sdr_req` with data 0x0123456789ABCDEF.
  - Required: `sdr_addr`=0x0012340 one cycle after `req`; `cpu_rdy` one cycle after `sdr_rdy`; `cpu_dout`=0x0123456789ABCDEF; `aud_dout` stays 0.
- Simultaneous requests, `CPU_BURST`=4: `cpu_req` and `aud_req` held high continuously -> grant order CPU,CPU,CPU,CPU,AUD, repeating; `owner` sequence 01,01,01,01,10.
- `CPU_BURST`=0: both requests high -> audio always granted first, CPU served when `aud_req` is low.
- Stray and dropped: `sdr_rdy` pulsed in IDLE -> no rdy, no data change. `aud_req` dropped during WAIT -> `aud_rdy` still pulses and `aud_dout` updates.
- Reset in WAIT: assert `reset` 2 cycles after `sdr_req` rises -> `sdr_req`=0, `owner`=00; after release, a held `cpu_req` is re-granted from IDLE with `sdr_req` one cycle later.

Source files
------------

// File: rtl/sdr_cpu_audio_arbiter_if.sv
// Signal bundle between the CPU ROM cache, the sound fetcher, the arbiter and the SDRAM controller.
// Latency: none (wires only).
// Backpressure: requesters hold req/addr until their rdy pulse; the arbiter holds sdr_req until sdr_rdy.
//
// Ports (modports):
//   master - arbiter view: samples cpu_*/aud_* requests and sdr_rdy/sdr_dout,
//            drives per-requester rdy/dout, sdr_req/sdr_addr, busy and owner.
//   slave  - environment view (requesters plus SDRAM controller), mirror image of master.
interface sdr_cpu_audio_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_req;
  logic              cpu_rdy;
  logic [DATA_W-1:0] cpu_dout;
  logic [ADDR_W-1:0] aud_addr;
  logic              aud_req;
  logic              aud_rdy;
  logic [DATA_W-1:0] aud_dout;
  logic [ADDR_W-1:0] sdr_addr;
  logic              sdr_req;
  logic              sdr_rdy;
  logic [DATA_W-1:0] sdr_dout;
  logic              busy;
  logic [1:0]        owner;

  modport master (
    input  cpu_addr, cpu_req, aud_addr, aud_req, sdr_rdy, sdr_dout,
    output cpu_rdy, cpu_dout, aud_rdy, aud_dout, sdr_addr, sdr_req, busy, owner
  );

  modport slave (
    output cpu_addr, cpu_req, aud_addr, aud_req, sdr_rdy, sdr_dout,
    input  cpu_rdy, cpu_dout, aud_rdy, aud_dout, sdr_addr, sdr_req, busy, owner
  );
endinterface

// File: rtl/sdr_cpu_audio_arbiter.sv
// Shares one SDRAM read channel between the CPU ROM cache and the audio fetcher, one transaction at a time.
// Latency: sdr_req one cycle after req is sampled in IDLE; rdy/dout one cycle after sdr_rdy; one RELEASE cycle after.
// Backpressure: sdr_req is a level held until sdr_rdy; requesters wait for their own rdy pulse.
//
// Ports:
//   clk_sys - system clock, all state on the rising edge
//   reset   - asynchronous, active-high; clears every register
//   bus     - master modport: cpu_*/aud_* requester pairs, sdr_* controller side, busy, owner
module sdr_cpu_audio_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 64,
  parameter int CPU_BURST = 4
) (
  input logic                     clk_sys,
  input logic                     reset,
  sdr_cpu_audio_arbiter_if.master bus
);
  // With CPU_BURST=0 the streak never leaves zero, so one bit is enough.
  localparam int STREAK_W = (CPU_BURST > 0) ? $clog2(CPU_BURST + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CPU_BURST);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_AUD  = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RELEASE} state_t;

  state_t              state_q, state_nxt;
  logic [ADDR_W-1:0]   sdr_addr_q, sdr_addr_nxt;
  logic                sdr_req_q, sdr_req_nxt;
  logic [1:0]          owner_q, owner_nxt;
  logic                cpu_rdy_q, cpu_rdy_nxt;
  logic                aud_rdy_q, aud_rdy_nxt;
  logic [DATA_W-1:0]   cpu_dout_q, cpu_dout_nxt;
  logic [DATA_W-1:0]   aud_dout_q, aud_dout_nxt;
  logic [STREAK_W-1:0] streak_q, streak_nxt;
  logic                busy_q;
  logic                aud_wins;

  always_comb begin
    state_nxt    = state_q;
    sdr_addr_nxt = sdr_addr_q;
    sdr_req_nxt  = sdr_req_q;
    owner_nxt    = owner_q;
    cpu_rdy_nxt  = 1'b0;
    aud_rdy_nxt  = 1'b0;
    cpu_dout_nxt = cpu_dout_q;
    aud_dout_nxt = aud_dout_q;
    streak_nxt   = streak_q;

    // Audio takes the grant when the CPU is silent or has used up its burst allowance.
    aud_wins = bus.aud_req && (!bus.cpu_req || (streak_q == STREAK_MAX));

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req || bus.aud_req) begin
          state_nxt   = ST_WAIT;
          sdr_req_nxt = 1'b1;
          if (aud_wins) begin
            owner_nxt    = OWN_AUD;
            sdr_addr_nxt = bus.aud_addr;
            streak_nxt   = '0;
          end else begin
            owner_nxt    = OWN_CPU;
            sdr_addr_nxt = bus.cpu_addr;
            // Only CPU grants that keep audio waiting count toward the starvation limit.
            if (!bus.aud_req) begin
              streak_nxt = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_nxt = streak_q + STREAK_W'(1);
            end
          end
        end
      end
      ST_WAIT: begin
        if (bus.sdr_rdy) begin
          // Only the owner's data register is touched, the other keeps its last value.
          if (owner_q == OWN_CPU) begin
            cpu_dout_nxt = bus.sdr_dout;
            cpu_rdy_nxt  = 1'b1;
          end else begin
            aud_dout_nxt = bus.sdr_dout;
            aud_rdy_nxt  = 1'b1;
          end
          sdr_req_nxt = 1'b0;
          state_nxt   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Dead cycle gives the served requester time to drop req before IDLE resamples it.
        owner_nxt = OWN_NONE;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sdr_addr_q <= '0;
      sdr_req_q  <= 1'b0;
      owner_q    <= OWN_NONE;
      cpu_rdy_q  <= 1'b0;
      aud_rdy_q  <= 1'b0;
      cpu_dout_q <= '0;
      aud_dout_q <= '0;
      streak_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      sdr_addr_q <= sdr_addr_nxt;
      sdr_req_q  <= sdr_req_nxt;
      owner_q    <= owner_nxt;
      cpu_rdy_q  <= cpu_rdy_nxt;
      aud_rdy_q  <= aud_rdy_nxt;
      cpu_dout_q <= cpu_dout_nxt;
      aud_dout_q <= aud_dout_nxt;
      streak_q   <= streak_nxt;
      busy_q     <= (state_nxt != ST_IDLE);
    end
  end

  assign bus.sdr_addr = sdr_addr_q;
  assign bus.sdr_req  = sdr_req_q;
  assign bus.owner    = owner_q;
  assign bus.cpu_rdy  = cpu_rdy_q;
  assign bus.aud_rdy  = aud_rdy_q;
  assign bus.cpu_dout = cpu_dout_q;
  assign bus.aud_dout = aud_dout_q;
  assign bus.busy     = busy_q;
endmodule
